// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART state encoding and timing helper (RX and TX sides).
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    function automatic int clks_per_bit(input int sys_clk, input int bps);
        return sys_clk / bps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Purpose  : 8N1 byte receiver: line synchronizer, bit-timing FSM, shifter.
// Revision : 1.0
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_byte_ok,
    output logic       o_stop_err,
    output logic [7:0] o_byte,
    output logic       o_start_acc,
    output logic       o_start_edge,
    output logic       o_idle,
    output logic       o_busy
);

    localparam int                  c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0]  c_BIT_END  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_HALF_END = c_CNT_W'(HALF_BIT - 1);

    logic               r_sync1, r_sync2, r_prev;
    uart_state_t        r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_bit, w_bit_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               w_fall, w_start_acc, w_byte_ok, w_stop_err;

    // Synchronizer and edge-detect flops idle high like the line itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall = r_prev & ~r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_start_acc = 1'b0;
        w_byte_ok   = 1'b0;
        w_stop_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end
            end
            ST_START: begin
                if (r_cnt == c_HALF_END) begin
                    w_cnt_nxt = '0;
                    if (!r_sync2) begin
                        w_state_nxt = ST_DATA;
                        w_bit_nxt   = '0;
                        w_start_acc = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (r_cnt == c_BIT_END) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop lets a start bit right after the stop bit be caught
                if (r_cnt == c_BIT_END) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    w_byte_ok   = r_sync2;
                    w_stop_err  = ~r_sync2;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_byte_ok    = w_byte_ok;
    assign o_stop_err   = w_stop_err;
    assign o_byte       = r_shift;
    assign o_start_acc  = w_start_acc;
    assign o_start_edge = (r_state == ST_IDLE) & w_fall;
    assign o_idle       = (r_state == ST_IDLE);
    assign o_busy       = (r_state == ST_DATA) | (r_state == ST_STOP);

endmodule
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_rx
// Purpose  : UART receiver packing NUM_BYTES bytes per frame, with timeout.
// Revision : 1.0
// ============================================================================
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int SYS_CLK      = 50000000,
    parameter int BPS          = 115200,
    parameter int NUM_BYTES    = 6,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_uart,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    output logic [NUM_BYTES*8-1:0] frame_data,
    output logic                   frame_valid,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int                 c_CLKS_PER_BIT = clks_per_bit(SYS_CLK, BPS);
    localparam int                 c_HALF_BIT     = c_CLKS_PER_BIT / 2;
    localparam int                 c_TO_LIMIT     = TIMEOUT_BITS * c_CLKS_PER_BIT;
    localparam int                 c_TO_W         = $clog2(c_TO_LIMIT + 1);
    localparam logic [c_TO_W-1:0]  c_TO_END       = c_TO_W'(c_TO_LIMIT - 1);
    localparam logic [3:0]         c_LAST_IDX     = 4'(NUM_BYTES - 1);

    logic                   w_byte_ok, w_stop_err, w_start_acc, w_start_edge, w_idle;
    logic [7:0]             w_rx_byte;
    logic [3:0]             r_idx;
    logic [c_TO_W-1:0]      r_to_cnt;
    logic [7:0]             r_slot [NUM_BYTES];
    logic [NUM_BYTES*8-1:0] w_frame;
    logic                   w_to_run, w_to_expire;

    uart_rx_byte #(
        .CLKS_PER_BIT (c_CLKS_PER_BIT),
        .HALF_BIT     (c_HALF_BIT)
    ) u_rx_byte (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx         (rx_uart),
        .o_byte_ok    (w_byte_ok),
        .o_stop_err   (w_stop_err),
        .o_byte       (w_rx_byte),
        .o_start_acc  (w_start_acc),
        .o_start_edge (w_start_edge),
        .o_idle       (w_idle),
        .o_busy       (busy)
    );

    // The slot being completed takes the incoming byte directly so the frame
    // register can load in the same cycle as byte_data.
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_slot[i] <= '0;
            end else if (w_byte_ok && (r_idx == 4'(i))) begin
                r_slot[i] <= w_rx_byte;
            end
        end
        assign w_frame[i*8 +: 8] = (r_idx == 4'(i)) ? w_rx_byte : r_slot[i];
    end

    // A falling edge in the expiry cycle wins over the timeout
    assign w_to_run    = w_idle && (r_idx != 4'd0);
    assign w_to_expire = w_to_run && !w_start_edge && (r_to_cnt == c_TO_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_start_acc || (r_idx == 4'd0)) begin
            r_to_cnt <= '0;
        end else if (w_to_run && !w_start_edge) begin
            r_to_cnt <= w_to_expire ? '0 : r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (w_byte_ok) begin
                byte_data  <= w_rx_byte;
                byte_valid <= 1'b1;
                if (r_idx == c_LAST_IDX) begin
                    frame_data  <= w_frame;
                    frame_valid <= 1'b1;
                    r_idx       <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else if (w_stop_err || w_to_expire) begin
                frame_err <= 1'b1;
                r_idx     <= '0;
            end
        end
    end

endmodule
`default_nettype wire
